// File: rtl/rs_entry_issue_array.sv
// Reservation-station entry array with CDB wakeup, dual allocation and a two-slot issue register.
// Optional macro RS_CDB_BYPASS_EN: a dispatching source that matches a same-cycle CDB tag is stored ready.
module rs_entry_issue_array #(
  parameter int RS_SIZE   = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [1:0]               disp_valid,
  input  logic [4*TAG_W-1:0]       disp_src_tag,
  input  logic [3:0]               disp_src_rdy,
  input  logic [2*PAYLOAD_W-1:0]   disp_payload,
  input  logic [1:0]               cdb_valid,
  input  logic [2*TAG_W-1:0]       cdb_tag,
  output logic [RS_SIZE-1:0]       rs_ready,
  input  logic [RS_SIZE-1:0]       gnt0,
  input  logic [RS_SIZE-1:0]       gnt1,
  input  logic                     iss_stall,
  output logic [1:0]               iss_valid,
  output logic [2*PAYLOAD_W-1:0]   iss_payload,
  output logic [CNT_W-1:0]         rs_free_cnt,
  output logic                     rs_full
);

  function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                   input logic [1:0] vld,
                                   input logic [2*TAG_W-1:0] tags);
    return (vld[0] && (tags[TAG_W-1:0] == tag)) ||
           (vld[1] && (tags[2*TAG_W-1:TAG_W] == tag));
  endfunction

  function automatic logic [RS_SIZE-1:0] lowest_one(input logic [RS_SIZE-1:0] v);
    return v & (~v + {{(RS_SIZE-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [RS_SIZE-1:0] v);
    logic [CNT_W-1:0] pc;
    pc = {CNT_W{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      pc = pc + CNT_W'(v[i]);
    end
    return pc;
  endfunction

  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [RS_SIZE-1:0]   rdy1_q, rdy1_d;
  logic [RS_SIZE-1:0]   rdy2_q, rdy2_d;
  logic [TAG_W-1:0]     tag1_q [RS_SIZE];
  logic [TAG_W-1:0]     tag1_d [RS_SIZE];
  logic [TAG_W-1:0]     tag2_q [RS_SIZE];
  logic [TAG_W-1:0]     tag2_d [RS_SIZE];
  logic [PAYLOAD_W-1:0] pay_q  [RS_SIZE];
  logic [PAYLOAD_W-1:0] pay_d  [RS_SIZE];

  logic [1:0]             iss_valid_q, iss_valid_d;
  logic [2*PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
  logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
  logic                   full_q, full_d;

  logic [RS_SIZE-1:0]   rdy_vec_s;
  logic [RS_SIZE-1:0]   g0_s, g1_s;
  logic [RS_SIZE-1:0]   a0_s, a1_s, alloc0_s, alloc1_s;
  logic [PAYLOAD_W-1:0] sel0_s, sel1_s;
  logic [3:0]           new_rdy_s;

  assign rdy_vec_s = valid_q & rdy1_q & rdy2_q;
  assign rs_ready  = rdy_vec_s;

  // Grants are qualified by readiness and stall; an overlapping gnt1 bit loses to gnt0.
  assign g0_s = lowest_one(gnt0 & rdy_vec_s) & {RS_SIZE{~iss_stall}};
  assign g1_s = lowest_one(gnt1 & rdy_vec_s & ~g0_s) & {RS_SIZE{~iss_stall}};

  // Allocation only sees entries free at the start of the cycle.
  assign a0_s     = lowest_one(~valid_q);
  assign a1_s     = lowest_one(~valid_q & ~a0_s);
  assign alloc0_s = a0_s & {RS_SIZE{disp_valid[0]}};
  assign alloc1_s = a1_s & {RS_SIZE{disp_valid[1]}};

  // Readiness of the four dispatching sources
  always_comb begin
    new_rdy_s = disp_src_rdy;
`ifdef RS_CDB_BYPASS_EN
    for (int k = 0; k < 4; k++) begin
      if (cdb_hit(disp_src_tag[k*TAG_W +: TAG_W], cdb_valid, cdb_tag)) begin
        new_rdy_s[k] = 1'b1;
      end else begin
        new_rdy_s[k] = disp_src_rdy[k];
      end
    end
`else
    new_rdy_s = disp_src_rdy;
`endif
  end

  // AND-OR payload mux for the granted entries
  always_comb begin
    sel0_s = {PAYLOAD_W{1'b0}};
    sel1_s = {PAYLOAD_W{1'b0}};
    for (int i = 0; i < RS_SIZE; i++) begin
      sel0_s = sel0_s | (pay_q[i] & {PAYLOAD_W{g0_s[i]}});
      sel1_s = sel1_s | (pay_q[i] & {PAYLOAD_W{g1_s[i]}});
    end
  end

  // Entry next state: free on issue, write on allocate, wake up on CDB match
  always_comb begin
    valid_d = (valid_q & ~g0_s & ~g1_s) | alloc0_s | alloc1_s;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    pay_d   = pay_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (alloc0_s[i]) begin
        tag1_d[i] = disp_src_tag[0*TAG_W +: TAG_W];
        tag2_d[i] = disp_src_tag[1*TAG_W +: TAG_W];
        rdy1_d[i] = new_rdy_s[0];
        rdy2_d[i] = new_rdy_s[1];
        pay_d[i]  = disp_payload[0 +: PAYLOAD_W];
      end else if (alloc1_s[i]) begin
        tag1_d[i] = disp_src_tag[2*TAG_W +: TAG_W];
        tag2_d[i] = disp_src_tag[3*TAG_W +: TAG_W];
        rdy1_d[i] = new_rdy_s[2];
        rdy2_d[i] = new_rdy_s[3];
        pay_d[i]  = disp_payload[PAYLOAD_W +: PAYLOAD_W];
      end else begin
        rdy1_d[i] = rdy1_q[i] | cdb_hit(tag1_q[i], cdb_valid, cdb_tag);
        rdy2_d[i] = rdy2_q[i] | cdb_hit(tag2_q[i], cdb_valid, cdb_tag);
      end
    end
  end

  // Issue register and free-count next state
  always_comb begin
    iss_valid_d   = iss_valid_q;
    iss_payload_d = iss_payload_q;
    if (!iss_stall) begin
      iss_valid_d = {|g1_s, |g0_s};
      if (|g0_s) begin
        iss_payload_d[0 +: PAYLOAD_W] = sel0_s;
      end else begin
        iss_payload_d[0 +: PAYLOAD_W] = iss_payload_q[0 +: PAYLOAD_W];
      end
      if (|g1_s) begin
        iss_payload_d[PAYLOAD_W +: PAYLOAD_W] = sel1_s;
      end else begin
        iss_payload_d[PAYLOAD_W +: PAYLOAD_W] = iss_payload_q[PAYLOAD_W +: PAYLOAD_W];
      end
    end else begin
      iss_valid_d   = iss_valid_q;
      iss_payload_d = iss_payload_q;
    end
    free_cnt_d = popcount(~valid_d);
    full_d     = (free_cnt_d < CNT_W'(2));
  end

  // Entry storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= {RS_SIZE{1'b0}};
      rdy1_q  <= {RS_SIZE{1'b0}};
      rdy2_q  <= {RS_SIZE{1'b0}};
      for (int i = 0; i < RS_SIZE; i++) begin
        tag1_q[i] <= {TAG_W{1'b0}};
        tag2_q[i] <= {TAG_W{1'b0}};
        pay_q[i]  <= {PAYLOAD_W{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      pay_q   <= pay_d;
    end
  end

  // Issue register and status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_q   <= 2'b00;
      iss_payload_q <= {(2*PAYLOAD_W){1'b0}};
      free_cnt_q    <= CNT_W'(RS_SIZE);
      full_q        <= 1'b0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_payload_q <= iss_payload_d;
      free_cnt_q    <= free_cnt_d;
      full_q        <= full_d;
    end
  end

  assign iss_valid   = iss_valid_q;
  assign iss_payload = iss_payload_q;
  assign rs_free_cnt = free_cnt_q;
  assign rs_full     = full_q;

`ifndef SYNTHESIS
  rs_entry_issue_array_chk #(.RS_SIZE(RS_SIZE), .CNT_W(CNT_W)) u_chk (
    .clock       (clock),
    .reset_n     (reset_n),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rs_free_cnt (free_cnt_q)
  );
`endif

endmodule

// Protocol checker: overlapping grants and an out-of-range free count.
module rs_entry_issue_array_chk #(
  parameter int RS_SIZE = 8,
  parameter int CNT_W   = 4
) (
  input logic               clock,
  input logic               reset_n,
  input logic [RS_SIZE-1:0] gnt0,
  input logic [RS_SIZE-1:0] gnt1,
  input logic [CNT_W-1:0]   rs_free_cnt
);

  a_gnt_overlap: assert property (@(posedge clock) disable iff (!reset_n)
    ((gnt0 & gnt1) == {RS_SIZE{1'b0}}))
    else $error("rs_entry_issue_array: gnt0 and gnt1 overlap");

  a_free_range: assert property (@(posedge clock) disable iff (!reset_n)
    (rs_free_cnt <= CNT_W'(RS_SIZE)))
    else $error("rs_entry_issue_array: free count out of range");

endmodule

// File: tb/tb_rs_entry_issue_array.sv
// Directed bench for rs_entry_issue_array: issue outputs go through a scoreboard queue.
module tb_rs_entry_issue_array;
  localparam int RS = 8;
  localparam int TW = 6;
  localparam int PW = 64;
  localparam int CW = 4;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [1:0]        disp_valid;
  logic [4*TW-1:0]   disp_src_tag;
  logic [3:0]        disp_src_rdy;
  logic [2*PW-1:0]   disp_payload;
  logic [1:0]        cdb_valid;
  logic [2*TW-1:0]   cdb_tag;
  logic [RS-1:0]     rs_ready;
  logic [RS-1:0]     gnt0;
  logic [RS-1:0]     gnt1;
  logic              iss_stall;
  logic [1:0]        iss_valid;
  logic [2*PW-1:0]   iss_payload;
  logic [CW-1:0]     rs_free_cnt;
  logic              rs_full;

  rs_entry_issue_array #(.RS_SIZE(RS), .TAG_W(TW), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .disp_valid   (disp_valid),
    .disp_src_tag (disp_src_tag),
    .disp_src_rdy (disp_src_rdy),
    .disp_payload (disp_payload),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .rs_ready     (rs_ready),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .iss_stall    (iss_stall),
    .iss_valid    (iss_valid),
    .iss_payload  (iss_payload),
    .rs_free_cnt  (rs_free_cnt),
    .rs_full      (rs_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      v;
    logic [2*PW-1:0] p;
    logic [2*PW-1:0] m;
  } iss_exp_t;

  iss_exp_t sbq[$];
  int checks   = 0;
  int failures = 0;

  localparam logic [2*PW-1:0] M0 = {{PW{1'b0}}, {PW{1'b1}}};
  localparam logic [2*PW-1:0] M1 = {{PW{1'b1}}, {PW{1'b0}}};
  localparam logic [2*PW-1:0] MB = {(2*PW){1'b1}};
  localparam logic [2*PW-1:0] MN = {(2*PW){1'b0}};

  task automatic chk(input string tag, input logic [2*PW-1:0] obs, input logic [2*PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_valid   = 2'b00;
    disp_src_tag = {(4*TW){1'b0}};
    disp_src_rdy = 4'b0000;
    disp_payload = {(2*PW){1'b0}};
    cdb_valid    = 2'b00;
    cdb_tag      = {(2*TW){1'b0}};
    gnt0         = {RS{1'b0}};
    gnt1         = {RS{1'b0}};
    iss_stall    = 1'b0;
  endtask

  task automatic dispatch(input logic [1:0] v, input logic [4*TW-1:0] tags, input logic [3:0] rdy,
                          input logic [PW-1:0] p1, input logic [PW-1:0] p0);
    disp_valid   = v;
    disp_src_tag = tags;
    disp_src_rdy = rdy;
    disp_payload = {p1, p0};
  endtask

  task automatic exp_iss(input logic [1:0] v, input logic [PW-1:0] p1, input logic [PW-1:0] p0,
                         input logic [2*PW-1:0] m);
    iss_exp_t e;
    e.v = v;
    e.p = {p1, p0};
    e.m = m;
    sbq.push_back(e);
  endtask

  task automatic pop_iss(input string tag);
    iss_exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_valid"}, {126'd0, iss_valid}, {126'd0, e.v});
      if (e.m != MN) chk({tag, "_payload"}, iss_payload & e.m, e.p & e.m);
    end
  endtask

  task automatic status(input string tag, input logic [RS-1:0] rdy, input logic [CW-1:0] cnt, input logic full);
    chk({tag, "_ready"}, {120'd0, rs_ready}, {120'd0, rdy});
    chk({tag, "_free"}, {124'd0, rs_free_cnt}, {124'd0, cnt});
    chk({tag, "_full"}, {127'd0, rs_full}, {127'd0, full});
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    step();
    step();
    status("reset", 8'h00, 4'd8, 1'b0);
    chk("reset_iss_valid", {126'd0, iss_valid}, {128{1'b0}});
    reset_n = 1'b1;

    // Two ready instructions land in entries 0 and 1
    dispatch(2'b11, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b1111, 64'hA1, 64'hA0);
    step();
    idle();
    status("disp2", 8'h03, 4'd6, 1'b0);

    // Entry 2 waits on tag 5, entry 3 is ready
    dispatch(2'b11, {6'd0, 6'd0, 6'd0, 6'd5}, 4'b1110, 64'hA3, 64'hA2);
    step();
    idle();
    status("disp_wait", 8'h0B, 4'd4, 1'b0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd5};
    step();
    idle();
    status("wake_cdb0", 8'h0F, 4'd4, 1'b0);

    // Entry 4 waits on tags 12 and 7; invalid CDBs must not wake it
    dispatch(2'b01, {6'd0, 6'd0, 6'd7, 6'd12}, 4'b1100, 64'h0, 64'hA4);
    step();
    idle();
    status("disp_two_wait", 8'h0F, 4'd3, 1'b0);
    cdb_valid = 2'b00;
    cdb_tag   = {6'd7, 6'd12};
    step();
    idle();
    status("cdb_invalid", 8'h0F, 4'd3, 1'b0);
    cdb_valid = 2'b11;
    cdb_tag   = {6'd7, 6'd12};
    step();
    idle();
    status("wake_both", 8'h1F, 4'd3, 1'b0);

    // Dual issue of entries 1 and 2
    gnt0 = 8'h02;
    gnt1 = 8'h04;
    exp_iss(2'b11, 64'hA2, 64'hA1, MB);
    step();
    idle();
    pop_iss("issue2");
    status("issue2", 8'h19, 4'd5, 1'b0);
    exp_iss(2'b00, 64'h0, 64'h0, MN);
    step();
    pop_iss("no_grant");

    gnt0 = 8'h01;
    exp_iss(2'b01, 64'h0, 64'hA0, M0);
    step();
    idle();
    pop_iss("issue_e0");
    status("issue_e0", 8'h18, 4'd6, 1'b0);

    // Stall: grants ignored, issue register holds
    iss_stall = 1'b1;
    gnt0      = 8'h08;
    gnt1      = 8'h10;
    exp_iss(2'b01, 64'h0, 64'hA0, M0);
    step();
    idle();
    pop_iss("stall");
    status("stall", 8'h18, 4'd6, 1'b0);

    // Grant on an invalid entry is ignored
    gnt0 = 8'h02;
    gnt1 = 8'h08;
    exp_iss(2'b10, 64'hA3, 64'h0, M1);
    step();
    idle();
    pop_iss("nonready_gnt");
    status("nonready_gnt", 8'h10, 4'd7, 1'b0);

    // Fill until one entry remains
    dispatch(2'b11, {(4*TW){1'b0}}, 4'b1111, 64'hB1, 64'hB0);
    step();
    idle();
    status("fill1", 8'h13, 4'd5, 1'b0);
    dispatch(2'b11, {(4*TW){1'b0}}, 4'b1111, 64'hB3, 64'hB2);
    step();
    dispatch(2'b11, {(4*TW){1'b0}}, 4'b1111, 64'hB6, 64'hB5);
    step();
    idle();
    status("fill3", 8'h7F, 4'd1, 1'b1);

    // One free entry: slot0 takes entry 7, slot1 dropped, freed entry 0 not reused
    dispatch(2'b11, {(4*TW){1'b0}}, 4'b1111, 64'hC1, 64'hC0);
    gnt0 = 8'h01;
    exp_iss(2'b01, 64'h0, 64'hB0, M0);
    step();
    idle();
    pop_iss("alloc_drop");
    status("alloc_drop", 8'hFE, 4'd1, 1'b1);
    gnt1 = 8'h80;
    exp_iss(2'b10, 64'hC0, 64'h0, M1);
    step();
    idle();
    pop_iss("issue_e7");
    status("issue_e7", 8'h7E, 4'd2, 1'b0);

    // Same-cycle CDB match on a dispatching source
    dispatch(2'b01, {6'd0, 6'd0, 6'd0, 6'd9}, 4'b1110, 64'h0, 64'hD0);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd9, 6'd0};
    step();
    idle();
`ifdef RS_CDB_BYPASS_EN
    status("bypass", 8'h7F, 4'd1, 1'b1);
    step();
    status("bypass_hold", 8'h7F, 4'd1, 1'b1);
`else
    status("bypass", 8'h7E, 4'd1, 1'b1);
    step();
    status("bypass_hold", 8'h7E, 4'd1, 1'b1);
`endif

    // Reset asserted mid-issue clears everything immediately
    gnt0 = 8'h02;
    gnt1 = 8'h04;
    exp_iss(2'b11, 64'hB2, 64'hB1, MB);
    step();
    idle();
    pop_iss("pre_reset");
    #2;
    reset_n = 1'b0;
    #1;
    status("mid_reset", 8'h00, 4'd8, 1'b0);
    chk("mid_reset_iss_valid", {126'd0, iss_valid}, {128{1'b0}});
    chk("mid_reset_payload", iss_payload, {128{1'b0}});
    step();
    reset_n = 1'b1;
    step();
    status("post_reset", 8'h00, 4'd8, 1'b0);

    chk("sb_drained", 128'(sbq.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
